// File: rtl/mem_rd_unaligned_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rd_unaligned_pkg
//  Description : Shared definitions for the unaligned load/store units on the
//                32-bit word-organised block memory. Holds the access-size
//                encodings, the load FSM state encoding and the straddle test
//                used by both the reader and the halfword writer.
//  Contents    : SZ_BYTE/SZ_HALF/SZ_WORD   access-size codes (2 bits)
//                ST_IDLE/ST_FIRST/ST_SECOND/ST_RESP   FSM states (2 bits)
//                straddles()               needs-a-second-word predicate
//  Revision    : 1.0  initial release
// ============================================================================
package mem_rd_unaligned_pkg;

   // Access-size encodings. The unused code 2'b11 is handled as a word.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Load FSM state encoding.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FIRST  = 2'd1;
   localparam logic [1:0] ST_SECOND = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // True when an access of the given size at the given byte offset spills
   // past the end of its word, i.e. the last byte lands in the next word.
   function automatic logic straddles(input logic [1:0] offset,
                                      input logic [1:0] size);
      logic result;
      result = 1'b0;
      case (size)
         SZ_BYTE:          result = 1'b0;
         SZ_HALF:          result = (offset == 2'd3);
         SZ_WORD, 2'b11:   result = (offset != 2'd0);
         default:          result = 1'b0;
      endcase
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rd_unaligned_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational byte extractor. Treats {first, second} as an
//                8-byte big-endian stream, picks 1, 2 or 4 bytes starting at
//                byte 'offset', right-justifies them and zero- or
//                sign-extends the result to 32 bits.
//  Ports       : first     [31:0] in   word holding the addressed byte
//                second    [31:0] in   following word (used when straddling)
//                offset    [1:0]  in   byte offset inside 'first'
//                size      [1:0]  in   SZ_BYTE / SZ_HALF / word (2'b1x)
//                is_signed        in   1 = sign-extend byte/half results
//                data      [31:0] out  extracted, extended result
//  Revision    : 1.0  initial release
// ============================================================================
module load_align
   import mem_rd_unaligned_pkg::*;
(
   input  logic [31:0] first,
   input  logic [31:0] second,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_signed,
   output logic [31:0] data
);

   logic [63:0] w_cat;
   logic [5:0]  w_lo;
   logic [31:0] w_win;
   logic        w_fill;

   always_comb begin
      w_cat = {first, second};
      // Byte k starts at bit 63-8k, so a 4-byte window beginning there has
      // its LSB at bit 32-8k. Byte and half results are the top of that
      // window, which keeps one shifter for all three sizes.
      w_lo  = 6'd32 - {1'b0, offset, 3'b000};
      w_win = w_cat[w_lo +: 32];
   end

   always_comb begin
      w_fill = is_signed & w_win[31];
      case (size)
         SZ_BYTE: data = {{24{w_fill}}, w_win[31:24]};
         SZ_HALF: data = {{16{w_fill}}, w_win[31:16]};
         default: data = w_win;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_rd_unaligned.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rd_unaligned
//  Description : Unaligned load unit for the 32-bit word-organised block
//                memory. Accepts a byte address and size, reads one or two
//                consecutive words through the synchronous read port and
//                returns the requested byte/half/word right-justified with
//                zero or sign extension.
//  Parameters  : ADDR_W               byte-address width (word addr ADDR_W-2)
//  Ports       : clk, rst_n           clock, async active-low reset
//                req_valid/req_ready  request handshake
//                req_addr  [ADDR_W-1:0] byte address
//                req_size  [1:0]      00 byte, 01 half, 1x word
//                req_signed           sign-extend byte/half
//                rsp_valid/rsp_ready  response handshake
//                rsp_data  [31:0]     result, stable while rsp_valid
//                mem_addr  [ADDR_W-3:0] word address to memory
//                mem_rdata [31:0]     memory data, one cycle after mem_addr
//  Revision    : 1.0  initial release
// ============================================================================
module mem_rd_unaligned
   import mem_rd_unaligned_pkg::*;
#(
   parameter int ADDR_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic [ADDR_W-3:0] mem_addr,
   input  logic [31:0]       mem_rdata
);

   localparam int               WA         = ADDR_W - 2;
   localparam logic [WA-1:0]    C_WORD_ONE = {{(WA-1){1'b0}}, 1'b1};

   logic [1:0]    r_state;
   logic [WA-1:0] r_word;
   logic [1:0]    r_off;
   logic [1:0]    r_size;
   logic          r_signed;
   logic [31:0]   r_first;
   logic [31:0]   r_second;
   logic [31:0]   r_rsp_data;

   logic          w_straddle;
   logic [WA-1:0] w_next_word;
   logic [31:0]   w_first_in;
   logic [31:0]   w_second_in;
   logic [31:0]   w_align;

   // ------------------------------------------------------------------------
   // Address generation and aligner operand selection
   // ------------------------------------------------------------------------
   always_comb begin
      w_straddle  = straddles(r_off, r_size);
      // Natural modulo-2^WA wrap: the word after the last one is word 0.
      w_next_word = r_word + C_WORD_ONE;

      case (r_state)
         ST_IDLE:  mem_addr = req_addr[ADDR_W-1:2];
         ST_FIRST: mem_addr = w_straddle ? w_next_word : r_word;
         default:  mem_addr = r_word;
      endcase

      // The word arriving this cycle is fed straight to the aligner so the
      // result can be registered in the same cycle it is captured.
      w_first_in  = (r_state == ST_FIRST)  ? mem_rdata : r_first;
      w_second_in = (r_state == ST_SECOND) ? mem_rdata : r_second;
   end

   load_align u_load_align (
      .first     (w_first_in),
      .second    (w_second_in),
      .offset    (r_off),
      .size      (r_size),
      .is_signed (r_signed),
      .data      (w_align)
   );

   // ------------------------------------------------------------------------
   // Control FSM and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_word     <= '0;
         r_off      <= 2'b00;
         r_size     <= SZ_BYTE;
         r_signed   <= 1'b0;
         r_first    <= 32'h0000_0000;
         r_second   <= 32'h0000_0000;
         r_rsp_data <= 32'h0000_0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_word   <= req_addr[ADDR_W-1:2];
                  r_off    <= req_addr[1:0];
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_state  <= ST_FIRST;
               end
            end
            ST_FIRST: begin
               r_first <= mem_rdata;
               if (w_straddle) begin
                  r_state <= ST_SECOND;
               end else begin
                  r_rsp_data <= w_align;
                  r_state    <= ST_RESP;
               end
            end
            ST_SECOND: begin
               r_second   <= mem_rdata;
               r_rsp_data <= w_align;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_unaligned.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_rd_unaligned
//  Description : Directed self-checking bench for mem_rd_unaligned with a
//                64-word synchronous-read memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_rd_unaligned;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_addr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [5:0]  mem_addr;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];

   int n_checks;
   int n_errors;

   mem_rd_unaligned #(.ADDR_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_signed (req_signed),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
   endtask

   // One load: request handshake, address/latency/data checks, optional
   // back-pressure of 'hold' cycles, then the response handshake. With
   // 'overlap' set, a byte request at 0x00 is presented during the response
   // handshake cycle and must not be taken until the cycle after.
   task automatic do_load(input logic [7:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] exp_data, input int exp_lat,
                          input logic [5:0] a0, input logic [5:0] a1,
                          input int hold, input bit overlap);
      int lat;
      wait_ready();
      req_valid  = 1'b1;
      req_addr   = addr;
      req_size   = size;
      req_signed = sgn;
      #1;
      chk("mem_addr_c0", {26'b0, mem_addr}, {26'b0, a0});
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_addr   = addr ^ 8'h5A;
      req_size   = ~size;
      req_signed = ~sgn;
      chk("req_ready_c1", {31'b0, req_ready}, 32'd0);
      chk("mem_addr_c1", {26'b0, mem_addr}, {26'b0, (exp_lat == 3) ? a1 : a0});
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("rsp_data", rsp_data, exp_data);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_rsp_data", rsp_data, exp_data);
         chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      if (overlap) begin
         req_valid  = 1'b1;
         req_addr   = 8'h00;
         req_size   = 2'b00;
         req_signed = 1'b0;
         #1;
         chk("req_ready_in_rsp_hs", {31'b0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
      chk("req_ready_after_hs", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      for (int i = 0; i < 64; i++) mem[i] = {8'hE0, 8'(i), 8'h5C, 8'(i)};
      mem[0]  = 32'h1122_3344;
      mem[1]  = 32'h5566_7788;
      mem[63] = 32'hAABB_CCDD;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = 8'h00;
      req_size   = 2'b00;
      req_signed = 1'b0;
      rsp_ready  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_rsp_data", rsp_data, 32'h0000_0000);
      rst_n = 1'b1;
      @(posedge clk); #1;

      //       addr   size   sgn   expected       lat a0  a1  hold ovl
      do_load(8'h02, 2'b01, 1'b0, 32'h0000_3344, 2, 0,  0,  0, 0);
      do_load(8'h03, 2'b01, 1'b0, 32'h0000_4455, 3, 0,  1,  0, 0);
      do_load(8'h01, 2'b10, 1'b0, 32'h2233_4455, 3, 0,  1,  0, 0);
      do_load(8'hFD, 2'b00, 1'b1, 32'hFFFF_FFBB, 2, 63, 63, 0, 0);
      do_load(8'hFD, 2'b00, 1'b0, 32'h0000_00BB, 2, 63, 63, 0, 0);
      do_load(8'hFE, 2'b10, 1'b0, 32'hCCDD_1122, 3, 63, 0,  0, 0);
      do_load(8'hFE, 2'b01, 1'b1, 32'hFFFF_CCDD, 2, 63, 63, 0, 0);
      do_load(8'hFF, 2'b01, 1'b1, 32'hFFFF_DD11, 3, 63, 0,  0, 0);
      do_load(8'h05, 2'b01, 1'b1, 32'h0000_6677, 2, 1,  1,  0, 0);
      do_load(8'h07, 2'b00, 1'b1, 32'hFFFF_FF88, 2, 1,  1,  0, 0);
      do_load(8'h04, 2'b11, 1'b1, 32'h5566_7788, 2, 1,  1,  0, 0);
      do_load(8'hFC, 2'b10, 1'b1, 32'hAABB_CCDD, 2, 63, 63, 0, 0);
      do_load(8'h00, 2'b01, 1'b1, 32'h0000_1122, 2, 0,  0,  0, 0);

      // Back-pressure, then a request overlapping the response handshake.
      do_load(8'h04, 2'b10, 1'b0, 32'h5566_7788, 2, 1,  1,  5, 1);
      do_load(8'h00, 2'b00, 1'b0, 32'h0000_0011, 2, 0,  0,  0, 0);

      // Reset while the second word is being fetched.
      wait_ready();
      req_valid  = 1'b1;
      req_addr   = 8'h01;
      req_size   = 2'b10;
      req_signed = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_mid_rsp_data", rsp_data, 32'h0000_0000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("no_stale_rsp", {31'b0, rsp_valid}, 32'd0);
      end
      do_load(8'h00, 2'b00, 1'b0, 32'h0000_0011, 2, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_rd_unaligned.md
# mem_rd_unaligned

Unaligned load unit for the lab's 32-bit word-organised block memory. It is the read-side counterpart of the unaligned halfword writer. It accepts a byte address plus an access size, fetches one or two consecutive words through the memory's synchronous read port, and extracts the requested byte, halfword or word. The result is returned right-justified with zero or sign extension. The block sits between the switch/button front end (or a CPU load path) and the `display`/register-file consumer.

## Interface
Parameters:
- `ADDR_W`, default 8: byte-address width. The word address is `ADDR_W-2` bits wide.

Ports:
- `clk`: input, 1 bit. The single clock; all state changes on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `req_valid`: input, 1 bit. A load request is present.
- `req_ready`: output, 1 bit. The block can accept a request; high only in IDLE.
- `req_addr`: input, `ADDR_W` bits. Byte address.
- `req_size`: input, 2 bits. 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `req_signed`: input, 1 bit. 1 = sign-extend, 0 = zero-extend.
- `rsp_valid`: output, 1 bit. Result available.
- `rsp_ready`: input, 1 bit. Consumer accepts the result.
- `rsp_data`: output, 32 bits. Extracted, extended result.
- `mem_addr`: output, `ADDR_W-2` bits. Word address to memory, read-only port.
- `mem_rdata`: input, 32 bits. Memory data, valid one cycle after `mem_addr`.

## Operation
- Byte order is big-endian within a word. Byte offset k (k = `addr[1:0]`) is `word[31-8k -: 8]`.
- Straddle condition (needs a second word):
  - half with offset 3;
  - word with offset ≠ 0.
  - A byte access never straddles.
- States:
  - IDLE:
    - `req_ready` = 1; `mem_addr` = `req_addr[ADDR_W-1:2]` (combinational).
    - On `req_valid`: latch addr, size and signed, then go to FIRST.
  - FIRST:
    - Capture `mem_rdata` into the first-word register.
    - If straddling: drive `mem_addr` = latched word + 1, go to SECOND.
    - Otherwise: compute the result into `rsp_data`, go to RESP.
  - SECOND:
    - Capture `mem_rdata` into the second-word register.
    - Compute the result from the 64-bit concatenation {first, second}, go to RESP.
  - RESP:
    - `rsp_valid` = 1; `rsp_data` is held stable.
    - On `rsp_ready`: go to IDLE.
- Extraction: take bytes k..k+n-1 of the first/second concatenation, where n is 1, 2 or 4. Place them in the LSBs and fill the upper bits with 0, or with the MSB of the extracted field when `req_signed` = 1.
- For word accesses, `req_signed` has no effect.
- Wrap-around: word address + 1 wraps modulo 2^(`ADDR_W-2`). For example, byte address 0xFE, word access: words 63 then 0.
- Inputs are sampled only at the request handshake. Changes to `req_*` outside the handshake are ignored.

## Timing
- Request handshake happens in cycle 0 (`req_valid` && `req_ready`).
- Latency from handshake to `rsp_valid`:
  - 2 cycles for a single-word access;
  - 3 cycles for a straddling access.
- `mem_addr` sequence:
  - first word during cycle 0;
  - for a straddling access, the second word during cycle 1.
- `req_ready` is low from cycle 1 until the cycle after the response handshake. No request is accepted in the same cycle as the response handshake.
- Reset values:
  - state IDLE, so `req_ready` = 1;
  - `rsp_valid` = 0, `rsp_data` = 0x00000000;
  - internal word registers = 0.
- Reset asserted mid-operation (FIRST, SECOND or RESP): the state returns to IDLE immediately. Any pending result is discarded; no `rsp_valid` pulse is produced after release.

## Structure
- Shared package holds:
  - the size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - the state encoding (IDLE/FIRST/SECOND/RESP);
  - the function computing the straddle condition. The same function is reusable by the writer.
- One combinational sub-module, `load_align`, takes (first, second, offset, size, signed) and returns `rsp_data`. The FSM and registers live in the top module.

## Test plan
Memory preload: word0 = 0x11223344, word1 = 0x55667788, word63 = 0xAABBCCDD.
- Half, addr 0x02, unsigned → `rsp_data` = 0x00003344. `rsp_valid` 2 cycles after the handshake; `mem_addr` = 0 only.
- Half, addr 0x03, unsigned → 0x00004455. `rsp_valid` after 3 cycles; `mem_addr` 0 then 1.
- Word, addr 0x01 → 0x22334455. Byte, addr 0xFD, signed → 0xFFFFFFBB; same access unsigned → 0x000000BB.
- Word, addr 0xFE → 0xCCDD1122. `mem_addr` is 63 then 0 (wrap).
- Hold `rsp_ready` low for 5 cycles: `rsp_valid` and `rsp_data` stay stable and `req_ready` stays 0. The next request is accepted only the cycle after the response handshake.
- Assert `rst_n` low during SECOND: `rsp_valid` = 0 immediately and `req_ready` = 1. After release, no stale response appears, and a new byte read at addr 0x00 returns 0x00000011.
